// File: rtl/execute_unit.sv
// Multi-cycle MIPS execute stage: single-cycle ALU/shift/HI-LO moves, iterative MULTU/DIVU.
// Latency 1 cycle (simple ops) or WIDTH+1 cycles (MULTU/DIVU); en is ignored while not IDLE.
module execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             execute_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      4'h0: begin
        alu_res = operand_a + operand_b;
        alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (alu_res[WIDTH-1] != operand_a[WIDTH-1]);
      end
      4'h1: alu_res = operand_a + operand_b;
      4'h2: begin
        alu_res = operand_a - operand_b;
        alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (alu_res[WIDTH-1] != operand_a[WIDTH-1]);
      end
      4'h3: alu_res = operand_a & operand_b;
      4'h4: alu_res = operand_a | operand_b;
      4'h5: alu_res = operand_a ^ operand_b;
      4'h6: alu_res = ~(operand_a | operand_b);
      4'h7: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      4'h8: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      4'h9: alu_res = operand_b << shamt;
      4'hA: alu_res = operand_b >> shamt;
      4'hB: alu_res = $unsigned($signed(operand_b) >>> shamt);
      4'hE: alu_res = hi_q;
      4'hF: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // rem_q/quo_q form {HI,LO}: multiply shifts right adding dvs_q, divide shifts left subtracting it.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    if (mul_q) begin
      step_rem = mul_sum[WIDTH:1];
      step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_rem = div_diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = div_shift[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    mul_d    = mul_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (alu_op == 4'hC || alu_op == 4'hD) begin
            state_d = S_ITER;
            cnt_d   = '0;
            busy_d  = 1'b1;
            rem_d   = '0;
            quo_d   = operand_a;
            dvs_d   = operand_b;
            mul_d   = (alu_op == 4'hC);
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          hi_d     = step_rem;
          lo_d     = step_quo;
          result_d = step_quo;
          zero_d   = (step_quo == '0);
          ovf_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      mul_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result       = result_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;
  assign execute_done = done_q;
endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: hand-computed vectors, all comparisons through chk.
module tb_execute_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, overflow, busy, execute_done;

  int n_checks = 0;
  int n_fail = 0;

  execute_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .shamt(shamt),
    .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .execute_done(execute_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single-cycle op: result must be present with done in the cycle after the en edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output logic z,
                       output logic ov, output logic d1, output logic d2);
    @(negedge clk);
    en = 1'b1; alu_op = op; operand_a = a; operand_b = b; shamt = sh;
    @(negedge clk);
    res = result; z = zero; ov = overflow; d1 = execute_done;
    en = 1'b0;
    @(negedge clk);
    d2 = execute_done;
  endtask

  // Long op: counts busy cycles and done pulses over a bounded window; optional ADD
  // injection and async reset at given cycle numbers (0 = none).
  task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input int rst_at,
                          output int first_done, output int busy_cycles, output int pulses,
                          output logic [31:0] res_at_done, output logic busy_at_rst);
    first_done = -1; busy_cycles = 0; pulses = 0; res_at_done = '0; busy_at_rst = 1'b1;
    @(negedge clk);
    en = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (execute_done) begin
        pulses++;
        if (first_done < 0) begin
          first_done = k;
          res_at_done = result;
        end
      end
      en = 1'b0;
      if (k == inj_at) begin
        en = 1'b1; alu_op = 4'h0; operand_a = 32'd1; operand_b = 32'd1;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1 busy_at_rst = busy;
      end
      if (rst_at != 0 && k == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  logic [31:0] r;
  logic        z, ov, d1, d2, brst;
  int          fd, bc, np;

  initial begin
    #2;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", execute_done, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(4'h0, 32'h7FFFFFFF, 32'h1, 5'd0, r, z, ov, d1, d2);
    chk("add_res", r, 64'h80000000);
    chk("add_ovf", ov, 1);
    chk("add_zero", z, 0);
    chk("add_done", d1, 1);
    chk("add_done_pulse", d2, 0);

    do_op(4'h1, 32'h7FFFFFFF, 32'h1, 5'd0, r, z, ov, d1, d2);
    chk("addu_res", r, 64'h80000000);
    chk("addu_ovf", ov, 0);

    do_op(4'h2, 32'd5, 32'd5, 5'd0, r, z, ov, d1, d2);
    chk("sub_res", r, 0);
    chk("sub_zero", z, 1);
    chk("sub_ovf", ov, 0);

    do_op(4'h7, 32'hFFFFFFFF, 32'h1, 5'd0, r, z, ov, d1, d2);
    chk("slt_res", r, 1);
    do_op(4'h8, 32'hFFFFFFFF, 32'h1, 5'd0, r, z, ov, d1, d2);
    chk("sltu_res", r, 0);
    chk("sltu_zero", z, 1);
    do_op(4'hB, 32'h0, 32'h80000000, 5'd4, r, z, ov, d1, d2);
    chk("sra_res", r, 64'hF8000000);
    do_op(4'hA, 32'h0, 32'h80000000, 5'd4, r, z, ov, d1, d2);
    chk("srl_res", r, 64'h08000000);
    do_op(4'h9, 32'h0, 32'h00000003, 5'd31, r, z, ov, d1, d2);
    chk("sll_res", r, 64'h80000000);
    do_op(4'h6, 32'h0F0F0000, 32'h000000FF, 5'd0, r, z, ov, d1, d2);
    chk("nor_res", r, 64'hF0F0FF00);

    run_long(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, fd, bc, np, r, brst);
    chk("multu_done_cycle", fd, 33);
    chk("multu_busy_cycles", bc, 32);
    chk("multu_pulses", np, 1);
    chk("multu_lo", r, 1);
    do_op(4'hE, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("mfhi_mul", r, 64'hFFFFFFFE);
    do_op(4'hF, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("mflo_mul", r, 1);

    run_long(4'hD, 32'd100, 32'd7, 0, 0, fd, bc, np, r, brst);
    chk("divu_lo", r, 14);
    chk("divu_done_cycle", fd, 33);
    do_op(4'hE, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("divu_hi", r, 2);

    run_long(4'hD, 32'h1234, 32'h0, 0, 0, fd, bc, np, r, brst);
    chk("div0_lo", r, 64'hFFFFFFFF);
    chk("div0_pulses", np, 1);
    do_op(4'hE, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("div0_hi", r, 64'h1234);

    run_long(4'hC, 32'd3, 32'd5, 5, 0, fd, bc, np, r, brst);
    chk("inj_pulses", np, 1);
    chk("inj_done_cycle", fd, 33);
    chk("inj_result", r, 15);
    chk("inj_ovf", overflow, 0);

    run_long(4'hD, 32'd1000, 32'd3, 0, 10, fd, bc, np, r, brst);
    chk("rst_mid_busy", brst, 0);
    chk("rst_mid_pulses", np, 0);
    do_op(4'hE, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("rst_mid_hi", r, 0);
    do_op(4'hF, 32'h0, 32'h0, 5'd0, r, z, ov, d1, d2);
    chk("rst_mid_lo", r, 0);
    do_op(4'h0, 32'd2, 32'd3, 5'd0, r, z, ov, d1, d2);
    chk("post_rst_add", r, 5);
    chk("post_rst_done", d1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
